load_store_unit: RTL and testbench

//  Memory stage feeding the register-file write port. Accepts one load/store from execute,

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/load_align.sv | 19 +
 rtl/load_store_unit.sv | 97 +++++++++
 tb/tb_load_store_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: op field layout, size codes, FSM states and lane helpers for the load/store unit
package lsu_pkg;
  localparam int OP_ST = 3;
  localparam int OP_UNS = 2;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;
  typedef enum logic [1:0] {IDLE, REQ, WB} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return size == SIZE_H ? a[0] : size == SIZE_W ? |a : size != SIZE_B;
  endfunction
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    return size == SIZE_B ? BE_B << a : size == SIZE_H ? BE_H << {a[1], 1'b0} : BE_W;
  endfunction
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] w);
    return size == SIZE_B ? {4{w[7:0]}} : size == SIZE_H ? {2{w[15:0]}} : w;
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half of a read word and sign/zero-extends it
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] value
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    value = size == SIZE_B ? {{24{~uns & b[7]}}, b} :
            size == SIZE_H ? {{16{~uns & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage with req/ack data-memory handshake, load alignment and RF writeback
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [3:0]  ex_op,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        exc_align,
  output logic        exc_timeout,
  output logic [31:0] exc_addr
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0] op_addr, aligned;
  logic [1:0] op_size;
  logic op_uns;
  logic [4:0] op_rd;
  logic accept, bad, expire, acked, timed_out;
  load_align u_align (
    .rdata(dm_rdata),
    .addr(op_addr[1:0]),
    .size(op_size),
    .uns(op_uns),
    .value(aligned)
  );
  assign ex_ready = (state == IDLE) & ~rst;
  assign dm_addr = {op_addr[31:2], 2'b00};
  always_comb begin
    accept = ex_valid & ex_ready;
    bad = misaligned(ex_op[1:0], ex_addr[1:0]);
    expire = cnt == CW'(TIMEOUT - 1);
    acked = (state == REQ) & dm_ack;
    timed_out = (state == REQ) & ~dm_ack & expire;
    state_n = state == IDLE ? (accept & ~bad ? REQ : IDLE) :
              state == REQ ? (dm_ack ? (dm_we ? IDLE : WB) : expire ? IDLE : REQ) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op_addr <= '0;
      op_size <= '0;
      op_uns <= 1'b0;
      op_rd <= '0;
      dm_req <= 1'b0;
      dm_we <= 1'b0;
      dm_be <= '0;
      dm_wdata <= '0;
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      exc_align <= 1'b0;
      exc_timeout <= 1'b0;
      exc_addr <= '0;
    end else begin
      state <= state_n;
      dm_req <= state_n == REQ;
      cnt <= state == REQ ? cnt + 1'b1 : '0;
      exc_align <= accept & bad;
      exc_timeout <= timed_out;
      rf_we <= acked & ~dm_we & |op_rd;
      if (accept & bad) exc_addr <= ex_addr;
      if (timed_out) exc_addr <= op_addr;
      if (accept & ~bad) begin
        op_addr <= ex_addr;
        op_size <= ex_op[1:0];
        op_uns <= ex_op[OP_UNS];
        op_rd <= ex_rd;
        dm_we <= ex_op[OP_ST];
        dm_be <= lane_be(ex_op[1:0], ex_addr[1:0]);
        dm_wdata <= store_data(ex_op[1:0], ex_wdata);
      end
      if (acked & ~dm_we) begin
        rf_wdata <= aligned;
        rf_waddr <= op_rd;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table, random ops against a byte-level model, reset/ack corner cases
module tb_load_store_unit;
  logic clk = 0, rst = 1, ex_valid = 0, ex_ready, dm_req, dm_we, dm_ack = 0;
  logic rf_we, exc_align, exc_timeout;
  logic [3:0] ex_op = 0, dm_be;
  logic [31:0] ex_addr = 0, ex_wdata = 0, dm_addr, dm_wdata, dm_rdata = 0, rf_wdata, exc_addr;
  logic [4:0] ex_rd = 0, rf_waddr;
  int checks = 0, errors = 0;
  localparam int TO = 15;
  always #5 clk = ~clk;
  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .exc_align(exc_align),
    .exc_timeout(exc_timeout), .exc_addr(exc_addr)
  );
  typedef struct {
    logic [3:0] op; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata;
    logic [4:0] rd; int delay; logic [3:0] be; logic [31:0] val; int kind;
  } vec_t;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int n = v.op[1:0] == 0 ? 1 : v.op[1:0] == 1 ? 2 : 4;
    int k = int'(v.addr[1:0]);
    logic [31:0] s;
    r.kind = (v.op[1:0] == 3 || k % n != 0) ? 1 : v.delay >= TO ? 2 : 0;
    r.be = 0;
    for (int i = 0; i < 4; i++) if (i >= k && i < k + n) r.be[i] = 1;
    if (v.op[3]) begin
      for (int i = 0; i < 4; i++) r.val[8*i +: 8] = v.wdata[8*(i % n) +: 8];
    end else begin
      s = v.rdata >> (8 * k);
      if (n < 4) begin
        s = s & ((32'd1 << (8 * n)) - 1);
        if (!v.op[2] && s[8*n-1]) s = s | ~((32'd1 << (8 * n)) - 1);
      end
      r.val = s;
    end
    return r;
  endfunction
  task automatic run_op(input vec_t v, input string tag);
    int reqc = 0, rfc = 0, ac = 0, tc = 0, cyc = 0;
    logic [3:0] be = 0;
    logic [31:0] addr = 0, wd = 0, rfd = 0;
    logic we = 0;
    logic [4:0] rfa = 0;
    check({tag, " ready"}, 32'(ex_ready), 32'd1);
    ex_valid = 1; ex_op = v.op; ex_addr = v.addr; ex_wdata = v.wdata; ex_rd = v.rd;
    dm_rdata = v.rdata;
    tick();
    ex_valid = 0; ex_op = $urandom; ex_addr = $urandom; ex_wdata = $urandom;
    while (cyc < 40) begin
      cyc++;
      if (dm_req) begin
        reqc++; be = dm_be; addr = dm_addr; wd = dm_wdata; we = dm_we;
      end
      if (rf_we) begin rfc++; rfd = rf_wdata; rfa = rf_waddr; end
      if (exc_align) ac++;
      if (exc_timeout) tc++;
      dm_ack = dm_req && reqc == v.delay + 1;
      if (ex_ready) break;
      tick();
    end
    dm_ack = 0;
    check({tag, " done"}, 32'(cyc < 40), 32'd1);
    check({tag, " align"}, ac, v.kind == 1 ? 1 : 0);
    check({tag, " timeout"}, tc, v.kind == 2 ? 1 : 0);
    check({tag, " reqcyc"}, reqc, v.kind == 1 ? 0 : v.kind == 2 ? TO : v.delay + 1);
    if (v.kind != 0) begin
      check({tag, " rf_we"}, rfc, 0);
      check({tag, " exc_addr"}, exc_addr, v.addr);
    end else begin
      check({tag, " be"}, 32'(be), 32'(v.be));
      check({tag, " dm_addr"}, addr, {v.addr[31:2], 2'b00});
      check({tag, " dm_we"}, 32'(we), 32'(v.op[3]));
      if (v.op[3]) begin
        check({tag, " dm_wdata"}, wd, v.val);
        check({tag, " rf_we"}, rfc, 0);
      end else begin
        check({tag, " rf_we"}, rfc, v.rd != 0 ? 1 : 0);
        if (v.rd != 0) begin
          check({tag, " rf_wdata"}, rfd, v.val);
          check({tag, " rf_waddr"}, 32'(rfa), 32'(v.rd));
        end
      end
    end
  endtask
  vec_t tbl[10];
  vec_t rv;
  initial begin
    tbl[0] = '{4'b0000, 32'h1003, 0, 32'h80FF_0000, 5'd3, 0, 4'b1000, 32'hFFFF_FF80, 0};
    tbl[1] = '{4'b0101, 32'h2002, 0, 32'h8001_1234, 5'd7, 1, 4'b1100, 32'h0000_8001, 0};
    tbl[2] = '{4'b0001, 32'h2002, 0, 32'h8001_1234, 5'd8, 0, 4'b1100, 32'hFFFF_8001, 0};
    tbl[3] = '{4'b1000, 32'h0001, 32'h1234_56AB, 0, 5'd9, 0, 4'b0010, 32'hABAB_ABAB, 0};
    tbl[4] = '{4'b0010, 32'h0006, 0, 0, 5'd4, 0, 4'b0000, 0, 1};
    tbl[5] = '{4'b0010, 32'h0040, 0, 0, 5'd4, 99, 4'b0000, 0, 2};
    tbl[6] = '{4'b0010, 32'h0044, 0, 32'hDEAD_BEEF, 5'd0, 2, 4'b1111, 32'hDEAD_BEEF, 0};
    tbl[7] = '{4'b0010, 32'h0048, 0, 32'hCAFE_F00D, 5'd31, 14, 4'b1111, 32'hCAFE_F00D, 0};
    tbl[8] = '{4'b1101, 32'h0102, 32'h5555_CDEF, 0, 5'd1, 3, 4'b1100, 32'hCDEF_CDEF, 0};
    tbl[9] = '{4'b0011, 32'h0100, 0, 0, 5'd2, 0, 4'b0000, 0, 1};
    #1;
    tick();
    check("rst ex_ready", 32'(ex_ready), 0);
    check("rst dm_req", 32'(dm_req), 0);
    check("rst rf_we", 32'(rf_we), 0);
    check("rst exc_addr", exc_addr, 0);
    check("rst be", 32'(dm_be), 0);
    rst = 0;
    #1;
    for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("vec%0d", i));
    dm_ack = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle ack dm_req", 32'(dm_req), 0);
      check("idle ack rf_we", 32'(rf_we), 0);
    end
    dm_ack = 0;
    ex_valid = 1; ex_op = 4'b0010; ex_addr = 32'h100; ex_rd = 5;
    tick();
    ex_valid = 0;
    check("rstmid dm_req", 32'(dm_req), 1);
    tick(); tick();
    rst = 1;
    tick();
    check("rstmid dm_req off", 32'(dm_req), 0);
    check("rstmid ready low", 32'(ex_ready), 0);
    check("rstmid no exc", 32'(exc_timeout | exc_align), 0);
    rst = 0; dm_ack = 1; dm_rdata = 32'h1111_2222;
    #1;
    check("rstmid ready", 32'(ex_ready), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstmid rf_we", 32'(rf_we), 0);
      check("rstmid req", 32'(dm_req), 0);
    end
    dm_ack = 0;
    for (int i = 0; i < 60; i++) begin
      rv.op = 4'($urandom);
      if ($urandom_range(0, 5) == 0) rv.op[1:0] = 2'b11;
      else if (rv.op[1:0] == 2'b11) rv.op[1:0] = 2'b10;
      rv.addr = $urandom;
      if ($urandom_range(0, 2) != 0) rv.addr[1:0] = rv.op[1:0] == 2'b10 ? 2'b00 : {rv.addr[1], 1'b0};
      rv.wdata = $urandom; rv.rdata = $urandom; rv.rd = 5'($urandom);
      rv.delay = $urandom_range(0, 9) == 0 ? $urandom_range(14, 16) : $urandom_range(0, 3);
      run_op(model(rv), $sformatf("rnd%0d", i));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
